flag_int_unit: RTL and testbench
================================

FLAG_INT_UNIT -- requirements
Module: flag_int_unit

Interface
REQ-001 The interface SHALL be one clock; reset is synchronous and active-low.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
REQ-004 C_IN  input  1  carry from ALU.
REQ-005 Z_IN  input  1  zero from ALU.
REQ-006 FLG_C_LD  input  1  load C from selected source.
REQ-007 FLG_Z_LD  input  1  load Z from selected source.
REQ-008 FLG_LD_SEL  input  1  source select: 0 = ALU (C_IN/Z_IN), 1 = shadow (return-from-interrupt).
REQ-009 FLG_C_SET  input  1  force C=1 (SEC).
REQ-010 FLG_C_CLR  input  1  force C=0 (CLC).
REQ-011 I_SET  input  1  enable interrupts (SEI).
REQ-012 I_CLR  input  1  disable interrupts (CLI).
REQ-013 INT_TAKEN  input  1  one-cycle strobe from control unit: interrupt vector taken.
REQ-014 INT_REQ  input  1  external interrupt request, asynchronous level.
REQ-015 BR_EN  input  1  conditional branch instruction active.
REQ-016 BR_COND  input  2  00 BRCC, 01 BRCS, 10 BREQ, 11 BRNE.
REQ-017 C_FLAG  output  1  registered carry flag.
REQ-018 Z_FLAG  output  1  registered zero flag.
REQ-019 I_FLAG  output  1  registered interrupt-enable flag.
REQ-020 INT_OUT  output  1  registered interrupt-pending to control unit.
REQ-021 BR_TAKE  output  1  combinational branch decision.

Function
REQ-022 C next-value priority SHALL be: FLG_C_CLR > FLG_C_SET > FLG_C_LD (source per FLG_LD_SEL) > hold.
REQ-023 Z next value SHALL be: FLG_Z_LD (source per FLG_LD_SEL) > hold.
REQ-024 Flag loads SHALL take effect one cycle after the load strobe, i.e., visible on C_FLAG/Z_FLAG after the next rising edge.
REQ-025 On INT_TAKEN, SHAD_C/SHAD_Z SHALL capture the current C_FLAG/Z_FLAG; otherwise the shadows hold.
REQ-026 If INT_TAKEN and a flag load occur in the same cycle, the shadows SHALL capture the pre-load flag values.
REQ-027 I next-value priority SHALL be: (INT_TAKEN or I_CLR) -> 0 > I_SET -> 1 > hold.
REQ-028 INT_REQ SHALL pass a two-flop synchronizer plus a third "previous" flop; rising edge = sync2 & ~prev.
REQ-029 Pending next SHALL be: 0 if INT_TAKEN or I_CLR; else pending | (edge & I_FLAG).
REQ-030 Edges arriving while I_FLAG=0 SHALL be dropped, not deferred.
REQ-031 Edges coinciding with INT_TAKEN SHALL be dropped.
REQ-032 Latency: with INT_REQ high and setup-met at edge k, I_FLAG=1, INT_OUT SHALL assert after edge k+2.
REQ-033 INT_OUT SHALL stay high until cleared per REQ-029; a held-high INT_REQ SHALL generate no further edges.
REQ-034 BR_TAKE SHALL be BR_EN & {~C_FLAG, C_FLAG, Z_FLAG, ~Z_FLAG}[BR_COND], using registered flags only, with no C_IN/Z_IN path.
REQ-035 INT_TAKEN without pending SHALL still save shadows and clear I.

Reset
REQ-036 With RST_N=0 at a rising edge: C_FLAG, Z_FLAG, SHAD_C, SHAD_Z, I_FLAG, pending, and all synchronizer flops SHALL become 0.
REQ-037 Reset SHALL override every other input in that cycle.
REQ-038 An INT_REQ level high through reset release SHALL NOT produce an edge until it falls and rises again.

Structure
REQ-039 Package rat_pkg SHALL hold br_cond_t (BRCC/BRCS/BREQ/BRNE) and flg_src_t (FLG_SRC_ALU/FLG_SRC_SHAD).
REQ-040 The synchronizer and edge detector SHALL be sub-module int_sync (CLK, RST_N, ASYNC_IN, EDGE_OUT).
REQ-041 No latches; one always_ff per state group and one always_comb for BR_TAKE.

Verification
REQ-042 The bench SHALL cover: C_IN=1, Z_IN=0, FLG_C_LD=FLG_Z_LD=1, SEL=0 -> next cycle C=1, Z=0; BR_COND=01, BR_EN=1 -> BR_TAKE=1.
REQ-043 The bench SHALL cover: FLG_C_SET=1 and FLG_C_CLR=1 with FLG_C_LD=1, C_IN=1 -> C=0.
REQ-044 The bench SHALL cover: I_SET, then INT_REQ pulse 0->1 -> INT_OUT=1 after edge k+2; INT_TAKEN -> INT_OUT=0, I=0, shadows=flags.
REQ-045 The bench SHALL cover: C=1, Z=1, INT_TAKEN; ISR sets C=0, Z=0; FLG_LD_SEL=1, both loads, I_SET -> C=1, Z=1, I=1.
REQ-046 The bench SHALL cover: I=0, INT_REQ rises then I_SET with INT_REQ held high -> INT_OUT stays 0.
REQ-047 The bench SHALL cover: all state nonzero, RST_N=0 for one edge -> all outputs 0; BR_COND=11, BR_EN=1 -> BR_TAKE=1.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared types for the flag / interrupt unit: branch condition codes and
// the flag-load source select.
package rat_pkg;

  typedef enum logic [1:0] {
    BRCC = 2'b00,
    BRCS = 2'b01,
    BREQ = 2'b10,
    BRNE = 2'b11
  } br_cond_t;

  typedef enum logic {
    FLG_SRC_ALU  = 1'b0,
    FLG_SRC_SHAD = 1'b1
  } flg_src_t;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer plus a "previous" flop for rising-edge detection of
// an asynchronous interrupt request level.
module int_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic ASYNC_IN,
  output logic EDGE_OUT
);
  localparam int STAGES = 2;

  logic              sync1, sync2, prev;
  logic [STAGES:0]   vld_pipe;

  // vld_pipe[k] marks that stage k holds a post-reset sample; the edge is
  // only trusted once prev is real, so a level held high through reset
  // release cannot masquerade as a rising edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync1    <= ASYNC_IN;
      sync2    <= sync1;
      prev     <= sync2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign EDGE_OUT = sync2 & ~prev & vld_pipe[STAGES];

endmodule

// File: rtl/flag_int_unit.sv
// Carry/zero/interrupt-enable flags with interrupt shadow save/restore,
// edge-triggered interrupt pending, and the conditional-branch decision.
module flag_int_unit
  import rat_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       C_IN,
  input  logic       Z_IN,
  input  logic       FLG_C_LD,
  input  logic       FLG_Z_LD,
  input  logic       FLG_LD_SEL,
  input  logic       FLG_C_SET,
  input  logic       FLG_C_CLR,
  input  logic       I_SET,
  input  logic       I_CLR,
  input  logic       INT_TAKEN,
  input  logic       INT_REQ,
  input  logic       BR_EN,
  input  logic [1:0] BR_COND,
  output logic       C_FLAG,
  output logic       Z_FLAG,
  output logic       I_FLAG,
  output logic       INT_OUT,
  output logic       BR_TAKE
);
  logic     shad_c, shad_z;
  logic     int_edge;
  logic     c_src, z_src;
  logic     br_hit;
  flg_src_t ld_src;

  assign ld_src = flg_src_t'(FLG_LD_SEL);
  assign c_src  = (ld_src == FLG_SRC_SHAD) ? shad_c : C_IN;
  assign z_src  = (ld_src == FLG_SRC_SHAD) ? shad_z : Z_IN;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      C_FLAG <= 1'b0;
      Z_FLAG <= 1'b0;
    end else begin
      if (FLG_C_CLR)      C_FLAG <= 1'b0;
      else if (FLG_C_SET) C_FLAG <= 1'b1;
      else if (FLG_C_LD)  C_FLAG <= c_src;
      if (FLG_Z_LD)       Z_FLAG <= z_src;
    end
  end

  // Shadows read the registered flags, so a same-cycle load is not seen.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shad_c <= 1'b0;
      shad_z <= 1'b0;
    end else if (INT_TAKEN) begin
      shad_c <= C_FLAG;
      shad_z <= Z_FLAG;
    end
  end

  int_sync u_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ASYNC_IN (INT_REQ),
    .EDGE_OUT (int_edge)
  );

  // Edges seen while disabled or during INT_TAKEN are dropped, not deferred.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      I_FLAG  <= 1'b0;
      INT_OUT <= 1'b0;
    end else begin
      if (INT_TAKEN || I_CLR) I_FLAG <= 1'b0;
      else if (I_SET)         I_FLAG <= 1'b1;
      if (INT_TAKEN || I_CLR) INT_OUT <= 1'b0;
      else                    INT_OUT <= INT_OUT | (int_edge & I_FLAG);
    end
  end

  always_comb begin
    br_hit = 1'b0;
    case (br_cond_t'(BR_COND))
      BRCC:    br_hit = ~C_FLAG;
      BRCS:    br_hit =  C_FLAG;
      BREQ:    br_hit =  Z_FLAG;
      BRNE:    br_hit = ~Z_FLAG;
      default: br_hit = 1'b0;
    endcase
    BR_TAKE = BR_EN & br_hit;
  end

endmodule

// File: tb/tb_flag_int_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_flag_int_unit;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       C_IN = 0, Z_IN = 0, FLG_C_LD = 0, FLG_Z_LD = 0, FLG_LD_SEL = 0;
  logic       FLG_C_SET = 0, FLG_C_CLR = 0, I_SET = 0, I_CLR = 0, INT_TAKEN = 0;
  logic       INT_REQ = 0, BR_EN = 0;
  logic [1:0] BR_COND = 2'b00;
  logic       C_FLAG, Z_FLAG, I_FLAG, INT_OUT, BR_TAKE;

  flag_int_unit dut (
    .CLK(CLK), .RST_N(RST_N), .C_IN(C_IN), .Z_IN(Z_IN),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .I_SET(I_SET), .I_CLR(I_CLR),
    .INT_TAKEN(INT_TAKEN), .INT_REQ(INT_REQ), .BR_EN(BR_EN), .BR_COND(BR_COND),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG), .INT_OUT(INT_OUT),
    .BR_TAKE(BR_TAKE)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit mc, mz, mi, msc, msz, mpend;
  bit samp_q[$];   // INT_REQ as sampled on each edge since reset (last 3 kept)

  // A rising edge is seen when the sample two edges back is 1 and the one
  // before it is a genuine post-reset 0.
  function automatic bit m_edge();
    int n = samp_q.size();
    return (n >= 3) && samp_q[n-2] && !samp_q[n-3];
  endfunction

  always @(posedge CLK) begin
    bit e, nc, nz, ni, np;
    e = m_edge();
    if (!RST_N) begin
      {mc, mz, mi, msc, msz, mpend} = '0;
      samp_q.delete();
    end else begin
      nc = FLG_C_CLR ? 1'b0 : FLG_C_SET ? 1'b1 :
           FLG_C_LD ? (FLG_LD_SEL ? msc : C_IN) : mc;
      nz = FLG_Z_LD ? (FLG_LD_SEL ? msz : Z_IN) : mz;
      ni = (INT_TAKEN || I_CLR) ? 1'b0 : I_SET ? 1'b1 : mi;
      np = (INT_TAKEN || I_CLR) ? 1'b0 : (mpend | (e & mi));
      if (INT_TAKEN) begin msc = mc; msz = mz; end
      mc = nc; mz = nz; mi = ni; mpend = np;
      samp_q.push_back(INT_REQ);
      if (samp_q.size() > 3) void'(samp_q.pop_front());
    end
  end

  // Single compare process: all outputs, every cycle, mid-period.
  always @(negedge CLK) begin
    bit tbl[4];
    if (cmp_en) begin
      tbl = '{~mc, mc, mz, ~mz};
      chk("c_flag",  C_FLAG,  mc);
      chk("z_flag",  Z_FLAG,  mz);
      chk("i_flag",  I_FLAG,  mi);
      chk("int_out", INT_OUT, mpend);
      chk("br_take", BR_TAKE, BR_EN & tbl[BR_COND]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    {FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_C_SET, FLG_C_CLR} = '0;
    {I_SET, I_CLR, INT_TAKEN, BR_EN} = '0;
    BR_COND = 2'b00;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  initial begin
    RST_N = 1'b0;
    tick(); cmp_en = 1;
    tick();
    chk("rst_c", C_FLAG, 1'b0); chk("rst_i", I_FLAG, 1'b0);
    chk("rst_int", INT_OUT, 1'b0);
    RST_N = 1'b1;
    tick(4);

    // ALU load, then BRCS taken
    C_IN = 1; Z_IN = 0; FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 0;
    tick(); idle();
    chk("alu_ld_c", C_FLAG, 1'b1); chk("alu_ld_z", Z_FLAG, 1'b0);
    BR_EN = 1; BR_COND = 2'b01; #1;
    chk("brcs", BR_TAKE, 1'b1);
    BR_COND = 2'b00; #1;
    chk("brcc", BR_TAKE, 1'b0);
    idle();

    // CLR beats SET beats LD
    FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; C_IN = 1;
    tick(); idle();
    chk("clr_prio", C_FLAG, 1'b0);
    FLG_C_SET = 1; FLG_C_LD = 1; C_IN = 0;
    tick(); idle();
    chk("set_prio", C_FLAG, 1'b1);

    // Interrupt latency, take, shadow save, ISR, restore
    I_SET = 1; C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
    tick(); idle();
    chk("sei", I_FLAG, 1'b1); chk("pre_z", Z_FLAG, 1'b1);
    INT_REQ = 1;              // sampled at edge k
    tick();                   // after k
    tick();                   // after k+1
    chk("int_k1", INT_OUT, 1'b0);
    tick();                   // after k+2
    chk("int_k2", INT_OUT, 1'b1);
    INT_TAKEN = 1;
    tick(); idle();
    chk("take_int", INT_OUT, 1'b0); chk("take_i", I_FLAG, 1'b0);
    FLG_C_CLR = 1; FLG_Z_LD = 1; Z_IN = 0;
    tick(); idle();
    chk("isr_c", C_FLAG, 1'b0); chk("isr_z", Z_FLAG, 1'b0);
    FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; I_SET = 1;
    tick(); idle();
    chk("rti_c", C_FLAG, 1'b1); chk("rti_z", Z_FLAG, 1'b1);
    chk("rti_i", I_FLAG, 1'b1);
    tick(4);
    chk("held_high", INT_OUT, 1'b0);

    // Edge while disabled is dropped
    I_CLR = 1; tick(); idle();
    INT_REQ = 0; tick(3);
    INT_REQ = 1; tick(3);
    I_SET = 1; tick(); idle();
    tick(4);
    chk("drop_dis", INT_OUT, 1'b0);

    // All state nonzero, then reset
    INT_REQ = 0; tick(3);
    INT_REQ = 1; tick(3);
    chk("pend_set", INT_OUT, 1'b1); chk("pre_rst_c", C_FLAG, 1'b1);
    RST_N = 0; tick(); RST_N = 1;
    chk("rst2_c", C_FLAG, 1'b0); chk("rst2_z", Z_FLAG, 1'b0);
    chk("rst2_i", I_FLAG, 1'b0); chk("rst2_int", INT_OUT, 1'b0);
    BR_EN = 1; BR_COND = 2'b11; #1;
    chk("brne_rst", BR_TAKE, 1'b1);
    idle();
    I_SET = 1; tick(); idle();
    tick(5);
    chk("rst_level", INT_OUT, 1'b0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      RST_N      = ($urandom_range(0, 99) != 0);
      C_IN       = $urandom; Z_IN = $urandom;
      FLG_C_LD   = ($urandom_range(0, 3) == 0);
      FLG_Z_LD   = ($urandom_range(0, 3) == 0);
      FLG_LD_SEL = $urandom;
      FLG_C_SET  = ($urandom_range(0, 7) == 0);
      FLG_C_CLR  = ($urandom_range(0, 7) == 0);
      I_SET      = ($urandom_range(0, 5) == 0);
      I_CLR      = ($urandom_range(0, 15) == 0);
      INT_TAKEN  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 4) == 0) INT_REQ = ~INT_REQ;
      BR_EN      = $urandom;
      BR_COND    = 2'($urandom);
      tick();
    end
    idle(); RST_N = 1;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
